// File: rtl/remote_comm.sv
// remote_comm: host-side remote-control link for the Knight robot.
//
// Sends a 16-bit command as two back-to-back 8N1 UART frames (high byte
// first) on TX, and receives single-byte 8N1 responses on RX.
//
// Parameters:
//   BAUD_DIV  clocks per UART bit (>= 16)
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   RX        serial input from robot, idles high
//   TX        serial output to robot, idles high (registered)
//   cmd       command word, captured when snd_cmd is accepted
//   snd_cmd   single-cycle send request, accepted only when idle/done
//   cmd_snt   level, both bytes of the last command transmitted
//   resp      last received byte
//   resp_rdy  level, resp holds a new byte
//
// Build option:
//   REMOTE_COMM_RX_SYNC_EN  two-flop RX synchronizer instead of one flop.

module remote_comm #(
   parameter int unsigned BAUD_DIV = 434
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        RX,
   output logic        TX,
   input  logic [15:0] cmd,
   input  logic        snd_cmd,
   output logic        cmd_snt,
   output logic [7:0]  resp,
   output logic        resp_rdy
);

   localparam int unsigned CntW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [CntW-1:0] BaudMax = CntW'(BAUD_DIV - 1);
   localparam logic [CntW-1:0] HalfMax = CntW'(BAUD_DIV / 2 - 1);
   localparam logic [CntW-1:0] CntOne  = CntW'(1);

   // ---------------------------------------------------------------------
   // Send side
   // ---------------------------------------------------------------------
   typedef enum logic [1:0] {StIdle, StHigh, StLow, StDone} tx_state_e;

   tx_state_e       tx_state_q, tx_state_d;
   logic [15:0]     cmd_q;
   logic [8:0]      tx_sr_q;     // remaining data bits plus stop bit
   logic [3:0]      tx_bit_q;
   logic [CntW-1:0] tx_baud_q;
   logic            tx_q;
   logic            cmd_snt_q;

   logic            accept;
   logic            tx_load;
   logic [7:0]      tx_load_byte;
   logic            set_snt;
   logic            tx_busy;
   logic            tx_bit_end;
   logic            tx_frame_end;

   assign tx_busy      = (tx_state_q == StHigh) || (tx_state_q == StLow);
   assign tx_bit_end   = (tx_baud_q == BaudMax);
   assign tx_frame_end = tx_bit_end && (tx_bit_q == 4'd9);

   always_comb begin
      tx_state_d   = tx_state_q;
      accept       = 1'b0;
      tx_load      = 1'b0;
      tx_load_byte = cmd_q[7:0];
      set_snt      = 1'b0;
      unique case (tx_state_q)
         StIdle, StDone: begin
            if (snd_cmd) begin
               accept       = 1'b1;
               tx_load      = 1'b1;
               tx_load_byte = cmd[15:8];
               tx_state_d   = StHigh;
            end else if (tx_state_q == StDone) begin
               tx_state_d = StIdle;
            end
         end
         StHigh: begin
            // Low byte starts on the same edge the high stop bit ends.
            if (tx_frame_end) begin
               tx_load    = 1'b1;
               tx_state_d = StLow;
            end
         end
         StLow: begin
            if (tx_frame_end) begin
               set_snt    = 1'b1;
               tx_state_d = StDone;
            end
         end
         default: tx_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state_q <= StIdle;
      end else begin
         tx_state_q <= tx_state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_q     <= '0;
         tx_sr_q   <= '1;
         tx_bit_q  <= '0;
         tx_baud_q <= '0;
         tx_q      <= 1'b1;
         cmd_snt_q <= 1'b0;
      end else begin
         if (accept) begin
            cmd_q <= cmd;
         end
         if (tx_load) begin
            tx_q      <= 1'b0;
            tx_sr_q   <= {1'b1, tx_load_byte};
            tx_bit_q  <= '0;
            tx_baud_q <= '0;
         end else if (tx_busy) begin
            if (tx_bit_end) begin
               tx_baud_q <= '0;
               if (tx_bit_q != 4'd9) begin
                  tx_q     <= tx_sr_q[0];
                  tx_sr_q  <= {1'b1, tx_sr_q[8:1]};
                  tx_bit_q <= tx_bit_q + 4'd1;
               end
            end else begin
               tx_baud_q <= tx_baud_q + CntOne;
            end
         end else begin
            tx_q      <= 1'b1;
            tx_bit_q  <= '0;
            tx_baud_q <= '0;
         end
         if (accept) begin
            cmd_snt_q <= 1'b0;
         end else if (set_snt) begin
            cmd_snt_q <= 1'b1;
         end
      end
   end

   assign TX      = tx_q;
   assign cmd_snt = cmd_snt_q;

   // ---------------------------------------------------------------------
   // Receive side
   // ---------------------------------------------------------------------
   logic rx_s;
   logic rx_hist_q;

`ifdef REMOTE_COMM_RX_SYNC_EN
   logic rx_meta_q, rx_sync_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
      end else begin
         rx_meta_q <= RX;
         rx_sync_q <= rx_meta_q;
      end
   end
   assign rx_s = rx_sync_q;
`else
   logic rx_sync_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_sync_q <= 1'b1;
      end else begin
         rx_sync_q <= RX;
      end
   end
   assign rx_s = rx_sync_q;
`endif

   typedef enum logic [1:0] {RxIdle, RxStart, RxData} rx_state_e;

   rx_state_e       rx_state_q, rx_state_d;
   logic [CntW-1:0] rx_baud_q;
   logic [3:0]      rx_bit_q;
   logic [7:0]      rx_sr_q;
   logic [7:0]      resp_q;
   logic            resp_rdy_q;

   logic rx_fall;
   logic rx_confirm;
   logic rx_sample;
   logic rx_done;

   assign rx_fall = rx_hist_q & ~rx_s;

   always_comb begin
      rx_state_d = rx_state_q;
      rx_confirm = 1'b0;
      rx_sample  = 1'b0;
      rx_done    = 1'b0;
      unique case (rx_state_q)
         RxIdle: begin
            if (rx_fall) begin
               rx_state_d = RxStart;
            end
         end
         RxStart: begin
            // Mid start bit: a high level means it was only a glitch.
            if (rx_baud_q == HalfMax) begin
               if (rx_s) begin
                  rx_state_d = RxIdle;
               end else begin
                  rx_confirm = 1'b1;
                  rx_state_d = RxData;
               end
            end
         end
         RxData: begin
            if (rx_baud_q == BaudMax) begin
               if (rx_bit_q == 4'd8) begin
                  rx_done    = 1'b1;
                  rx_state_d = RxIdle;
               end else begin
                  rx_sample = 1'b1;
               end
            end
         end
         default: rx_state_d = RxIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_state_q <= RxIdle;
      end else begin
         rx_state_q <= rx_state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_hist_q  <= 1'b1;
         rx_baud_q  <= '0;
         rx_bit_q   <= '0;
         rx_sr_q    <= '0;
         resp_q     <= '0;
         resp_rdy_q <= 1'b0;
      end else begin
         rx_hist_q <= rx_s;
         unique case (rx_state_q)
            RxStart: rx_baud_q <= (rx_baud_q == HalfMax) ? '0 : rx_baud_q + CntOne;
            RxData:  rx_baud_q <= (rx_baud_q == BaudMax) ? '0 : rx_baud_q + CntOne;
            default: rx_baud_q <= '0;
         endcase
         if (rx_state_q == RxIdle) begin
            rx_bit_q <= '0;
         end else if (rx_sample) begin
            rx_sr_q  <= {rx_s, rx_sr_q[7:1]};
            rx_bit_q <= rx_bit_q + 4'd1;
         end
         if (rx_done) begin
            resp_q <= rx_sr_q;
         end
         if (rx_done) begin
            resp_rdy_q <= 1'b1;
         end else if (rx_confirm || accept) begin
            resp_rdy_q <= 1'b0;
         end
      end
   end

   assign resp     = resp_q;
   assign resp_rdy = resp_rdy_q;

endmodule

// File: tb/tb_remote_comm.sv
// Directed self-checking bench for remote_comm, run with a short bit time.

module tb_remote_comm;

   localparam int B  = 16;
   localparam int HB = B / 2;

   logic        clk;
   logic        rst_n;
   logic        rx;
   logic        rx_drv;
   logic        loop_en;
   logic        tx;
   logic [15:0] cmd;
   logic        snd_cmd;
   logic        cmd_snt;
   logic [7:0]  resp;
   logic        resp_rdy;

   int checks = 0;
   int errors = 0;

   assign rx = loop_en ? tx : rx_drv;

   remote_comm #(.BAUD_DIV(B)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .RX       (rx),
      .TX       (tx),
      .cmd      (cmd),
      .snd_cmd  (snd_cmd),
      .cmd_snt  (cmd_snt),
      .resp     (resp),
      .resp_rdy (resp_rdy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; rx_drv = 1'b1; loop_en = 1'b0; snd_cmd = 1'b0; cmd = 16'h0000;
      #23;
      checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", tx); end
      checks++; if (cmd_snt !== 1'b0) begin errors++; $display("FAIL reset_cmd_snt got %b want 0", cmd_snt); end
      checks++; if (resp_rdy !== 1'b0) begin errors++; $display("FAIL reset_resp_rdy got %b want 0", resp_rdy); end
      checks++; if (resp !== 8'h00) begin errors++; $display("FAIL reset_resp got %h want 00", resp); end
      tick();
      rst_n = 1'b1;
      repeat (3) tick();
   endtask

   // Sends c and checks every bit at mid-bit; optionally fires a second
   // snd_cmd with c2 during the low byte, which must be ignored.
   task automatic test_send(input logic [15:0] c, input bit busy, input logic [15:0] c2);
      logic [7:0] byte_v;
      logic       exp;
      int         j;
      cmd = c; snd_cmd = 1'b1;
      tick();
      snd_cmd = 1'b0; cmd = ~c;
      checks++; if (tx !== 1'b0) begin errors++; $display("FAIL send_start got %b want 0", tx); end
      checks++; if (cmd_snt !== 1'b0) begin errors++; $display("FAIL send_snt_clr got %b want 0", cmd_snt); end
      repeat (HB) tick();
      for (int i = 0; i < 20; i++) begin
         byte_v = (i < 10) ? c[15:8] : c[7:0];
         j = i % 10;
         exp = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : byte_v[j-1];
         checks++;
         if (tx !== exp) begin
            errors++; $display("FAIL send_bit%0d cmd %h got %b want %b", i, c, tx, exp);
         end
         if (i < 19) begin
            if (busy && i == 13) begin
               cmd = c2; snd_cmd = 1'b1;
               tick();
               snd_cmd = 1'b0;
               repeat (B - 1) tick();
            end else begin
               repeat (B) tick();
            end
         end
      end
      repeat (HB - 1) tick();
      checks++; if (cmd_snt !== 1'b0) begin errors++; $display("FAIL send_snt_early got %b want 0", cmd_snt); end
      tick();
      checks++; if (cmd_snt !== 1'b1) begin errors++; $display("FAIL send_snt_at20 got %b want 1", cmd_snt); end
      repeat (2 * B) tick();
      checks++; if (cmd_snt !== 1'b1) begin errors++; $display("FAIL send_snt_hold got %b want 1", cmd_snt); end
      checks++; if (tx !== 1'b1) begin errors++; $display("FAIL send_tx_idle got %b want 1", tx); end
   endtask

   task automatic rx_bit(input logic v);
      rx_drv = v;
      repeat (B) tick();
   endtask

   task automatic rx_data_stop(input logic [7:0] d);
      for (int i = 0; i < 8; i++) rx_bit(d[i]);
      rx_bit(1'b1);
   endtask

   task automatic test_receive();
      rx_bit(1'b0);
      rx_data_stop(8'hA5);
      checks++; if (resp !== 8'hA5) begin errors++; $display("FAIL rx_first got %h want a5", resp); end
      checks++; if (resp_rdy !== 1'b1) begin errors++; $display("FAIL rx_first_rdy got %b want 1", resp_rdy); end
      rx_drv = 1'b0;
      repeat (3) tick();
      checks++; if (resp_rdy !== 1'b1) begin errors++; $display("FAIL rx_rdy_before_confirm got %b want 1", resp_rdy); end
      repeat (B - 3) tick();
      checks++; if (resp_rdy !== 1'b0) begin errors++; $display("FAIL rx_rdy_after_confirm got %b want 0", resp_rdy); end
      checks++; if (resp !== 8'hA5) begin errors++; $display("FAIL rx_resp_hold got %h want a5", resp); end
      rx_data_stop(8'h5A);
      checks++; if (resp !== 8'h5A) begin errors++; $display("FAIL rx_second got %h want 5a", resp); end
      checks++; if (resp_rdy !== 1'b1) begin errors++; $display("FAIL rx_second_rdy got %b want 1", resp_rdy); end
   endtask

   task automatic test_glitch();
      rx_drv = 1'b0;
      repeat (3) tick();
      rx_drv = 1'b1;
      repeat (2 * B) tick();
      checks++; if (resp_rdy !== 1'b1) begin errors++; $display("FAIL glitch_rdy got %b want 1", resp_rdy); end
      checks++; if (resp !== 8'h5A) begin errors++; $display("FAIL glitch_resp got %h want 5a", resp); end
      rx_bit(1'b0);
      rx_data_stop(8'h3C);
      checks++; if (resp !== 8'h3C) begin errors++; $display("FAIL glitch_recover got %h want 3c", resp); end
   endtask

   task automatic test_reset_mid();
      cmd = 16'h2000; snd_cmd = 1'b1;
      tick();
      snd_cmd = 1'b0;
      repeat (24) tick();
      checks++; if (tx !== 1'b0) begin errors++; $display("FAIL rstmid_pre_tx got %b want 0", tx); end
      rst_n = 1'b0;
      #1;
      checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rstmid_tx got %b want 1", tx); end
      checks++; if (cmd_snt !== 1'b0) begin errors++; $display("FAIL rstmid_snt got %b want 0", cmd_snt); end
      checks++; if (resp_rdy !== 1'b0) begin errors++; $display("FAIL rstmid_rdy got %b want 0", resp_rdy); end
      checks++; if (resp !== 8'h00) begin errors++; $display("FAIL rstmid_resp got %h want 00", resp); end
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (2) tick();
      test_send(16'hC33C, 1'b0, 16'h0000);
   endtask

   task automatic test_loopback();
      int n;
      loop_en = 1'b1;
      cmd = 16'h2000; snd_cmd = 1'b1;
      tick();
      snd_cmd = 1'b0;
      checks++; if (resp_rdy !== 1'b0) begin errors++; $display("FAIL loop_rdy_clr got %b want 0", resp_rdy); end
      n = 0;
      while (resp_rdy !== 1'b1 && n < 12 * B) begin tick(); n++; end
      checks++; if (resp_rdy !== 1'b1) begin errors++; $display("FAIL loop_first_timeout got %b want 1", resp_rdy); end
      checks++; if (resp !== 8'h20) begin errors++; $display("FAIL loop_first got %h want 20", resp); end
      n = 0;
      while (resp_rdy !== 1'b0 && n < 4 * B) begin tick(); n++; end
      checks++; if (resp_rdy !== 1'b0) begin errors++; $display("FAIL loop_confirm_timeout got %b want 0", resp_rdy); end
      n = 0;
      while (cmd_snt !== 1'b1 && n < 12 * B) begin tick(); n++; end
      checks++; if (cmd_snt !== 1'b1) begin errors++; $display("FAIL loop_snt_timeout got %b want 1", cmd_snt); end
      tick();
      checks++; if (resp_rdy !== 1'b1) begin errors++; $display("FAIL loop_second_rdy got %b want 1", resp_rdy); end
      checks++; if (resp !== 8'h00) begin errors++; $display("FAIL loop_second got %h want 00", resp); end
      loop_en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_send(16'h6020, 1'b0, 16'h0000);
      test_send(16'h6020, 1'b1, 16'h1234);
      test_receive();
      test_glitch();
      test_reset_mid();
      test_loopback();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
